adc_avg_alarm: RTL

- Sits directly downstream of the ADS7883 serial capture controller.
- Generates that controller's periodic start request (en_adc) and accepts each completed 12-bit signed conversion.
- Computes a moving average over 2^AVG_LOG2 samples and drives a debounced, hysteretic threshold alarm for the neck-check logic.

---
 rtl/adc_avg_alarm_if.sv | 39 +++
 rtl/adc_avg_alarm.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/adc_avg_alarm_if.sv
// ---------------------------------------------------------------------------
// adc_avg_alarm_if
// Bundles the sample handshake with the ADS7883 capture controller and the
// averaged/alarm results that go on to the neck-check logic.
//   en_adc     : one-cycle conversion request toward the capture controller
//   adc_upflag : data_upflag from the capture controller (multi-cycle level)
//   adc_data   : signed 12-bit conversion, stable while adc_upflag is high
//   avg_data   : signed 12-bit moving average
//   avg_valid  : one-cycle strobe, avg_data freshly updated
//   alarm      : debounced hysteretic threshold alarm
// slave  = the averaging block itself
// master = whoever supplies samples and consumes the results
// ---------------------------------------------------------------------------
interface adc_avg_alarm_if;
   logic               en_adc;
   logic               adc_upflag;
   logic signed [11:0] adc_data;
   logic signed [11:0] avg_data;
   logic               avg_valid;
   logic               alarm;

   modport slave (
      input  adc_upflag,
      input  adc_data,
      output en_adc,
      output avg_data,
      output avg_valid,
      output alarm
   );

   modport master (
      output adc_upflag,
      output adc_data,
      input  en_adc,
      input  avg_data,
      input  avg_valid,
      input  alarm
   );
endinterface

// File: rtl/adc_avg_alarm.sv
// ---------------------------------------------------------------------------
// adc_avg_alarm
// Requests conversions from the ADS7883 capture controller at a fixed rate,
// keeps a moving average over 2^AVG_LOG2 accepted samples and drives a
// debounced alarm with separate set (TH_HI) and clear (TH_LO) thresholds.
// Ports:
//   clk     : system clock
//   rst_n   : asynchronous reset, active low
//   enable  : block enable; low clears all state on the next edge
//   bus     : adc_avg_alarm_if.slave (sample handshake and results)
// Pipeline: accept edge (stb) -> output edge (avg) -> alarm edge.
// ---------------------------------------------------------------------------
module adc_avg_alarm #(
   parameter int                 SAMPLE_DIV = 1000,
   parameter int                 AVG_LOG2   = 3,
   parameter logic signed [11:0] TH_HI      = 12'sd1200,
   parameter logic signed [11:0] TH_LO      = 12'sd1000,
   parameter int                 DEBOUNCE   = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            enable,
   adc_avg_alarm_if.slave  bus
);

   localparam int N  = 1 << AVG_LOG2;
   localparam int SW = 12 + AVG_LOG2;
   localparam int PW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int FW = AVG_LOG2 + 1;
   localparam int TW = $clog2(SAMPLE_DIV + 1);

   localparam logic [TW-1:0] TIMER_LAST = TW'(SAMPLE_DIV - 1);
   localparam logic [PW-1:0] PTR_LAST   = PW'(N - 1);
   localparam logic [FW-1:0] FILL_FULL  = FW'(N);
   localparam logic [3:0]    DEB_LAST   = 4'(DEBOUNCE - 1);

   logic [TW-1:0]      timer_q, timer_d;
   logic               upflag_q;
   logic signed [11:0] bufMem_q [N];
   logic signed [SW-1:0] sum_q, sum_d;
   logic [PW-1:0]      wrPtr_q, wrPtr_d;
   logic [FW-1:0]      fill_q, fill_d;
   logic               outPend_q;
   logic signed [11:0] avgData_q, avgData_d;
   logic               avgValid_q, avgValid_d;
   logic               alarm_q, alarm_d;
   logic [3:0]         hiCnt_q, hiCnt_d;
   logic [3:0]         loCnt_q, loCnt_d;

   logic               stb;
   logic signed [SW-1:0] dataExt;
   logic signed [SW-1:0] oldExt;
   logic signed [SW-1:0] sumShift;

   // The request is decoded straight from the timer so it is high for exactly
   // the one cycle in which the counter sits at its last value.
   assign bus.en_adc    = (timer_q == TIMER_LAST);
   assign bus.avg_data  = avgData_q;
   assign bus.avg_valid = avgValid_q;
   assign bus.alarm     = alarm_q;

   // A flag pulse of any width yields a single strobe on its rising edge.
   assign stb     = bus.adc_upflag & ~upflag_q;
   assign dataExt = SW'(bus.adc_data);
   assign oldExt  = SW'(bufMem_q[wrPtr_q]);
   assign sumShift = sum_q >>> AVG_LOG2;

   // Free-running conversion timer, wrapping at SAMPLE_DIV-1.
   always_comb begin
      timer_d = timer_q + TW'(1);
      if (timer_q == TIMER_LAST) begin
         timer_d = '0;
      end
   end

   // Accept stage: the running sum swaps the oldest buffer entry for the new
   // sample. Entries start at zero, so the subtraction is also right while the
   // window is still filling.
   always_comb begin
      sum_d   = sum_q;
      wrPtr_d = wrPtr_q;
      fill_d  = fill_q;
      if (stb) begin
         sum_d   = sum_q + dataExt - oldExt;
         wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PW'(1);
         fill_d  = (fill_q == FILL_FULL) ? fill_q : fill_q + FW'(1);
      end
   end

   // Output stage: one edge after an accept, publish the floored average, but
   // only once the window holds a full N samples.
   always_comb begin
      avgData_d  = avgData_q;
      avgValid_d = 1'b0;
      if (outPend_q && (fill_q == FILL_FULL)) begin
         avgData_d  = sumShift[11:0];
         avgValid_d = 1'b1;
      end
   end

   // Alarm stage: only the counter for the direction that could change the
   // alarm is active; averages between the thresholds restart it.
   always_comb begin
      alarm_d = alarm_q;
      hiCnt_d = hiCnt_q;
      loCnt_d = loCnt_q;
      if (avgValid_q) begin
         if (!alarm_q) begin
            if (avgData_q >= TH_HI) begin
               if (hiCnt_q == DEB_LAST) begin
                  alarm_d = 1'b1;
                  hiCnt_d = '0;
               end else begin
                  hiCnt_d = hiCnt_q + 4'd1;
               end
            end else begin
               hiCnt_d = '0;
            end
         end else begin
            if (avgData_q <= TH_LO) begin
               if (loCnt_q == DEB_LAST) begin
                  alarm_d = 1'b0;
                  loCnt_d = '0;
               end else begin
                  loCnt_d = loCnt_q + 4'd1;
               end
            end else begin
               loCnt_d = '0;
            end
         end
      end
   end

   // State registers. upflag_q keeps following the flag while disabled so a
   // flag that is already high when enable rises does not count as a sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q    <= '0;
         upflag_q   <= 1'b0;
         sum_q      <= '0;
         wrPtr_q    <= '0;
         fill_q     <= '0;
         outPend_q  <= 1'b0;
         avgData_q  <= '0;
         avgValid_q <= 1'b0;
         alarm_q    <= 1'b0;
         hiCnt_q    <= '0;
         loCnt_q    <= '0;
         for (int i = 0; i < N; i++) begin
            bufMem_q[i] <= '0;
         end
      end else begin
         upflag_q <= bus.adc_upflag;
         if (!enable) begin
            timer_q    <= '0;
            sum_q      <= '0;
            wrPtr_q    <= '0;
            fill_q     <= '0;
            outPend_q  <= 1'b0;
            avgData_q  <= '0;
            avgValid_q <= 1'b0;
            alarm_q    <= 1'b0;
            hiCnt_q    <= '0;
            loCnt_q    <= '0;
            for (int i = 0; i < N; i++) begin
               bufMem_q[i] <= '0;
            end
         end else begin
            timer_q    <= timer_d;
            sum_q      <= sum_d;
            wrPtr_q    <= wrPtr_d;
            fill_q     <= fill_d;
            outPend_q  <= stb;
            avgData_q  <= avgData_d;
            avgValid_q <= avgValid_d;
            alarm_q    <= alarm_d;
            hiCnt_q    <= hiCnt_d;
            loCnt_q    <= loCnt_d;
            if (stb) begin
               bufMem_q[wrPtr_q] <= bus.adc_data;
            end
         end
      end
   end

endmodule
